// File: rtl/rx_block_if.sv
// Serial-side and byte-side signals of the UART receive stage.
// The master drives the line and oversample tick; the slave is the receiver.
interface rx_block_if;
    logic       clk_en;
    logic       rx_in;
    logic [7:0] mdata;
    logic       done;
    logic       frame_err;
    logic       busy;

    modport master (
        output clk_en,
        output rx_in,
        input  mdata,
        input  done,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  clk_en,
        input  rx_in,
        output mdata,
        output done,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/rx_block.sv
// UART 8N1 receiver: mid-bit sampling on an oversample tick, glitch filter, framing errors.
// Optional RX_MAJORITY_EN: each bit sample is a 3-tick majority vote of the synchronized line.
module rx_block #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    rx_block_if.slave  bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic          rx_meta_reg, rxs_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bitn_reg;
    logic [7:0]    sh_reg;
    logic [7:0]    mdata_reg;
    logic          done_reg, frame_err_reg;
    logic          sample_bit;

    logic          cnt_clear, cnt_inc, bitn_clear, bitn_inc, shift_en;
    logic          done_next, frame_err_next, busy;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= bus.rx_in;
            rxs_reg     <= rx_meta_reg;
        end
    end

`ifdef RX_MAJORITY_EN
    // The vote window is {two prior ticks, live rxs}; only the prior two need storage.
    logic [1:0] hist_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg <= 2'b11;
        end else if (bus.clk_en) begin
            hist_reg <= {hist_reg[0], rxs_reg};
        end
    end

    assign sample_bit = (rxs_reg & hist_reg[0]) | (rxs_reg & hist_reg[1]) |
                        (hist_reg[0] & hist_reg[1]);
`else
    assign sample_bit = rxs_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.clk_en) begin
            case (state_reg)
                IDLE: begin
                    if (!rxs_reg) state_next = START;
                end
                START: begin
                    if (cnt_reg == HALF_M1) state_next = sample_bit ? IDLE : DATA;
                end
                DATA: begin
                    if (cnt_reg == FULL_M1 && bitn_reg == 3'd7) state_next = STOP;
                end
                STOP: begin
                    if (cnt_reg == FULL_M1) state_next = sample_bit ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (rxs_reg) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;
        bitn_clear     = 1'b0;
        bitn_inc       = 1'b0;
        shift_en       = 1'b0;
        done_next      = 1'b0;
        frame_err_next = 1'b0;
        busy           = (state_reg != IDLE);
        if (bus.clk_en) begin
            case (state_reg)
                IDLE: begin
                    cnt_clear = !rxs_reg;
                end
                START: begin
                    if (cnt_reg == HALF_M1) begin
                        cnt_clear  = !sample_bit;
                        bitn_clear = !sample_bit;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == FULL_M1) begin
                        shift_en  = 1'b1;
                        cnt_clear = 1'b1;
                        bitn_inc  = (bitn_reg != 3'd7);
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == FULL_M1) begin
                        done_next      = sample_bit;
                        frame_err_next = !sample_bit;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath; done/frame_err are cleared every cycle so they stay one clk wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            bitn_reg      <= 3'd0;
            sh_reg        <= 8'h00;
            mdata_reg     <= 8'h00;
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            done_reg      <= done_next;
            frame_err_reg <= frame_err_next;
            if (cnt_clear) begin
                cnt_reg <= '0;
            end else if (cnt_inc) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (bitn_clear) begin
                bitn_reg <= 3'd0;
            end else if (bitn_inc) begin
                bitn_reg <= bitn_reg + 3'd1;
            end
            if (shift_en) begin
                sh_reg <= {sample_bit, sh_reg[7:1]};
            end
            if (done_next) begin
                mdata_reg <= sh_reg;
            end
        end
    end

    assign bus.mdata     = mdata_reg;
    assign bus.done      = done_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_rx_block.sv
// Scoreboard bench for rx_block: directed 8N1 frames plus randomized frames/tick rates,
// with expected byte/error events queued at stimulus time and checked by a monitor.
module tb_rx_block;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst;

    rx_block_if bus();

    rx_block #(.OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] last_good;
    int         checks   = 0;
    int         failures = 0;
    int         div      = 1;
    bit         mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Oversample tick: one clk wide, every div cycles.
    initial begin
        int dc = 0;
        bus.clk_en = 1'b0;
        forever begin
            @(negedge clk);
            if (dc >= div - 1) begin
                bus.clk_en = 1'b1;
                dc = 0;
            end else begin
                bus.clk_en = 1'b0;
                dc++;
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!bus.clk_en) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic v, input int ticks);
        @(negedge clk);
        bus.rx_in = v;
        wait_ticks(ticks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0, OS);
        for (int k = 0; k < 8; k++) drive_bit(d[k], OS);
        drive_bit(stop, OS);
    endtask

    // Reference: a good stop bit yields the byte; a bad one yields an error with mdata unchanged.
    task automatic expect_frame(input logic [7:0] d, input logic stop);
        ev_t ev;
        if (stop) begin
            ev.err = 1'b0;
            ev.data = d;
            last_good = d;
        end else begin
            ev.err = 1'b1;
            ev.data = last_good;
        end
        exp_q.push_back(ev);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_mdata"}, bus.mdata, 0);
        check({name, "_done"}, bus.done, 0);
        check({name, "_frame_err"}, bus.frame_err, 0);
        check({name, "_busy"}, bus.busy, 0);
    endtask

    // Monitor: pops one expected event for every done/frame_err pulse.
    initial begin
        bit  prev_pulse = 1'b0;
        ev_t ev;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (prev_pulse) check("pulse_width", {bus.done, bus.frame_err}, 0);
                if (bus.done || bus.frame_err) begin
                    check("done_err_exclusive", bus.done & bus.frame_err, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event: got done=%0b frame_err=%0b mdata=%0h expected no event",
                                 bus.done, bus.frame_err, bus.mdata);
                    end else begin
                        ev = exp_q.pop_front();
                        check("event_is_err", bus.frame_err, ev.err);
                        check("mdata", bus.mdata, ev.data);
                    end
                end
                prev_pulse = bus.done | bus.frame_err;
            end else begin
                prev_pulse = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] d;
        logic       v;
        logic       stop;

        rst = 1'b1;
        bus.rx_in = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame with latency check: done visible one cycle after the stop-sample tick.
        expect_frame(8'hA5, 1'b1);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                check("a5_done_early", bus.done, 0);
                @(negedge clk);
                check("a5_done_on_time", bus.done, 1);
            end
        join
        @(negedge clk);
        check("busy_after_a5", bus.busy, 0);
        drive_bit(1'b1, OS);

        // Back-to-back frames with no idle gap.
        expect_frame(8'h00, 1'b1);
        expect_frame(8'hFF, 1'b1);
        expect_frame(8'h3C, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1, OS);

        // Start-bit glitch of 4 clk: busy briefly, back to idle at the mid-start sample.
        @(negedge clk);
        bus.rx_in = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy", bus.busy, 1);
        repeat (6) @(negedge clk);
        check("glitch_idle", bus.busy, 0);
        repeat (20) @(negedge clk);

        // Bad stop bit followed by a 40-bit break.
        expect_frame(8'h55, 1'b0);
        pat = 8'h55;
        drive_bit(1'b0, OS);
        for (int k = 0; k < 8; k++) drive_bit(pat[k], OS);
        drive_bit(1'b0, OS);
        wait_ticks(20 * OS);
        check("break_busy_a", bus.busy, 1);
        check("break_mdata_held", bus.mdata, 8'h3C);
        wait_ticks(19 * OS);
        check("break_busy_b", bus.busy, 1);
        drive_bit(1'b1, 2 * OS);
        check("break_released", bus.busy, 0);
        expect_frame(8'h12, 1'b1);
        send_frame(8'h12, 1'b1);
        drive_bit(1'b1, OS);

        // Reset during data bit 4, then a frame at one tick every 4 clk.
        pat = 8'h99;
        drive_bit(1'b0, OS);
        for (int k = 0; k < 4; k++) drive_bit(pat[k], OS);
        @(negedge clk);
        bus.rx_in = pat[4];
        wait_ticks(5);
        @(negedge clk);
        rst = 1'b1;
        bus.rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        check_all_zero("after_reset");
        div = 4;
        repeat (40) @(negedge clk);
        expect_frame(8'h81, 1'b1);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, OS);

        // One-tick inverted spike exactly on each data bit's sample tick.
        div = 1;
        repeat (8) @(negedge clk);
        pat = 8'hF0;
`ifdef RX_MAJORITY_EN
        expect_frame(8'hF0, 1'b1);
`else
        expect_frame(8'h0F, 1'b1);
`endif
        drive_bit(1'b0, OS);
        for (int k = 0; k < 8; k++) begin
            v = pat[k];
            drive_bit(v, 8);
            drive_bit(~v, 1);
            drive_bit(v, OS - 9);
        end
        drive_bit(1'b1, OS);
        drive_bit(1'b1, OS);

        // Randomized frames, tick rates, stop-bit errors and idle gaps.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            div = $urandom_range(1, 3);
            d = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            expect_frame(d, stop);
            send_frame(d, stop);
            if (!stop) drive_bit(1'b1, OS * $urandom_range(1, 3));
            else if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 2 * OS));
        end
        drive_bit(1'b1, 2 * OS);

        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_block.md
# rx_block

UART receive stage: recovers 8N1 frames (start bit, 8 data bits LSB first, stop bit) from the serial line and presents each byte with a single-cycle strobe. It sits downstream of the UART line driven by the transmit stage and shares its 8N1 frame format. It runs from a shared oversample enable (`clk_en`, OVERSAMPLE ticks per bit) and samples at mid-bit. It reports framing errors and filters start-bit glitches.

## Interface
- `OVERSAMPLE`, default 16: `clk_en` ticks per bit. Must be even and ≥ 4.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `clk_en` input 1: oversample tick, one `clk` wide.
- `rx_in` input 1: serial line. Idle is high. May be asynchronous to `clk`.
- `mdata` output 8: last good byte. Reset value 8'h00. Holds until the next good frame.
- `done` output 1: one-cycle pulse when `mdata` updates. Reset value 0.
- `frame_err` output 1: one-cycle pulse when a bad stop bit is detected. Reset value 0.
- `busy` output 1: high in every state except IDLE. Reset value 0.

## Operation
- **Synchronizer:** 2-flop, reset to 1. `rxs` is the synchronizer output.
- **Tick counter:** `cnt`, width $clog2(OVERSAMPLE), reset 0. Increments only on `clk_en`.
- **Bit counter:** `bitn`, 3 bits.
- **Shift register:** `sh`, 8 bits.
- **FSM** (all transitions occur only on `clk_en` cycles):
  - IDLE: if `rxs`==0 → START, `cnt`<=0.
  - START: when `cnt`==OVERSAMPLE/2-1, sample the bit. Sample 1 → IDLE (glitch, no output). Sample 0 → DATA, with `cnt`<=0 and `bitn`<=0. Otherwise `cnt`++.
  - DATA: when `cnt`==OVERSAMPLE-1, sample the bit.
    - Shift it in: `sh`<={sample, `sh`[7:1]}.
    - Set `cnt`<=0.
    - If `bitn`==7 → STOP; else `bitn`++.
  - STOP: when `cnt`==OVERSAMPLE-1, sample the bit.
    - Sample 1: `mdata`<=`sh`, pulse `done`, → IDLE.
    - Sample 0: pulse `frame_err`, `mdata` unchanged, → WAIT_HIGH.
  - WAIT_HIGH: if `rxs`==1 → IDLE. This prevents a held-low line (break) from producing repeated frames.
- Leaving STOP at mid stop bit is required. The next start edge may arrive half a bit later.
- **Reset mid-frame:** all registers return to reset values and the FSM goes to IDLE. No `done` or `frame_err` pulse is emitted.

## Timing
- Rx-to-detection latency: 2 `clk` (synchronizer), plus up to 1 tick to detection.
- Let T0 be the tick at which IDLE sees `rxs`==0.
  - Start bit is sampled at tick T0+OVERSAMPLE/2.
  - Data bit k is sampled at tick T0+OVERSAMPLE/2+OVERSAMPLE·(k+1).
  - Stop bit is sampled at tick T0+OVERSAMPLE/2+9·OVERSAMPLE.
- `done`/`frame_err` rise on the `clk` edge that ends the stop-sample tick. They are high for exactly one `clk`.
- `mdata` is valid in the same cycle `done` is high.
- `busy` rises on the `clk` edge of the T0 tick. It falls on the edge that enters IDLE.
- `clk_en` low: all state, counters and outputs hold. `done` and `frame_err` are 0 in such cycles.
- `done` and `frame_err` are never high together.

## Configuration
- `RX_MAJORITY_EN` defined:
  - A 3-bit history of `rxs` shifts on every `clk_en`, reset 3'b111.
  - Every bit sample (start, data, stop) uses the majority of the history: the current tick and the two prior ticks.
  - The START glitch check also uses the majority value.
  - Sample tick positions are unchanged. IDLE detection still uses raw `rxs`.
- `RX_MAJORITY_EN` undefined: each sample is the single `rxs` value on the sample tick. No history register.

## Test plan
- Byte received correctly:
  - Stimulus: OVERSAMPLE=16, `clk_en` every cycle, frame 0xA5 at 16 `clk`/bit.
  - Response: `mdata`=8'hA5 and `done` pulses once, one cycle after tick T0+152. `frame_err` stays 0. `busy` low afterwards.
- Back-to-back frames:
  - Stimulus: 0x00, 0xFF, 0x3C back-to-back with no idle gap.
  - Response: three `done` pulses with `mdata`=00, FF, 3C. No `frame_err`.
- Start-bit glitch rejected:
  - Stimulus: `rx_in` low for 4 `clk`, then high.
  - Response: FSM returns to IDLE at T0+8. No `done`, no `frame_err`.
- Bad stop bit and break:
  - Stimulus: frame 0x55 with stop bit = 0, then the line held low for 40 bit times, then released high, then frame 0x12.
  - Response: exactly one `frame_err` pulse. `mdata` stays at its previous value. `busy` stays high until the line goes high. Then `done` fires with `mdata`=8'h12.
- Reset mid-frame and slow tick:
  - Stimulus: assert `rst` during data bit 4. Then, with `clk_en` every 4th cycle, send frame 0x81.
  - Response: all outputs read 0 during and right after reset. After reset, `mdata`=8'h81 and `done` is 1 `clk` wide.
- Majority filter (`RX_MAJORITY_EN` only):
  - Stimulus: frame 0xF0 with a 1-tick inverted spike at the sample tick of every data bit.
  - Response: `mdata`=8'hF0.
  - Without the macro, the same stimulus gives `mdata`=8'h0F (every data bit inverted).
